// File: rtl/alu_op_sequencer.sv
// Command-side sequencer for the external 4-bit ripple ALU: holds operands for a settle window,
// captures flags and returns them; ABS_DIFF re-issues a negate pass. Optional: ALU_SELFCHECK_EN.
//
// state | meaning
// IDLE  | accepting a command (cmd_ready=1)
// WAIT1 | first ALU pass settling
// WAIT2 | negate pass settling (negative ABS_DIFF only)
// RESP  | response held until rsp_ready
module alu_op_sequencer #(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [1:0]       cmd_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_overflow,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_overflow,
  output logic             rsp_zero,
  output logic             busy
`ifdef ALU_SELFCHECK_EN
  ,
  output logic             chk_err
`endif
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, WAIT1, WAIT2, RESP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          is_abs;
  logic          ov_sticky;
  logic          at_tc;

  assign at_tc     = (cnt == CNT_ONE);
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      is_abs       <= 1'b0;
      ov_sticky    <= 1'b0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_op       <= 2'b00;
      rsp_result   <= '0;
      rsp_overflow <= 1'b0;
      rsp_zero     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            alu_a     <= cmd_a;
            alu_b     <= cmd_b;
            alu_op    <= (cmd_op == 2'b01 || cmd_op == 2'b10) ? 2'b01 : 2'b00;
            is_abs    <= (cmd_op == 2'b10);
            ov_sticky <= 1'b0;
            cnt       <= CNT_LOAD;
            state     <= WAIT1;
          end
        end
        WAIT1: begin
          if (at_tc) begin
            rsp_result   <= alu_result;
            rsp_overflow <= alu_overflow;
            rsp_zero     <= alu_zero;
            // Negative difference: negate it through the ALU as 0 - result.
            if (is_abs && alu_result[WIDTH-1]) begin
              alu_a     <= '0;
              alu_b     <= alu_result;
              alu_op    <= 2'b01;
              ov_sticky <= alu_overflow;
              cnt       <= CNT_LOAD;
              state     <= WAIT2;
            end else begin
              cnt   <= '0;
              state <= RESP;
            end
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        WAIT2: begin
          if (at_tc) begin
            rsp_result   <= alu_result;
            rsp_overflow <= ov_sticky | alu_overflow;
            rsp_zero     <= alu_zero;
            cnt          <= '0;
            state        <= RESP;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_SELFCHECK_EN
  logic             sample_edge;
  logic [WIDTH-1:0] chk_expect;

  assign sample_edge = (state == WAIT1 || state == WAIT2) && at_tc;
  assign chk_expect  = alu_op[0] ? (alu_a - alu_b) : (alu_a + alu_b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_err <= 1'b0;
    end else if (sample_edge && (alu_result != chk_expect)) begin
      chk_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized bench for alu_op_sequencer with a settling ALU model and a transaction-level
// reference model; optional ALU_SELFCHECK_EN section exercises chk_err.
`timescale 1ns/1ps
module tb_alu_op_sequencer;
  localparam int WIDTH = 4;
  localparam int S     = 3;
  localparam int MAXS  = 7;
  localparam int MINS  = -8;

  logic             clk;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_a, cmd_b;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] alu_a, alu_b;
  logic [1:0]       alu_op;
  logic [WIDTH-1:0] alu_result;
  logic             alu_overflow, alu_zero;
  logic             rsp_valid, rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_overflow, rsp_zero;
  logic             busy;
`ifdef ALU_SELFCHECK_EN
  logic             chk_err;
`endif

  int n_cmp = 0;
  int n_err = 0;
  bit corrupt_add = 0;

  alu_op_sequencer #(.WIDTH(WIDTH), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_overflow(alu_overflow), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_overflow(rsp_overflow), .rsp_zero(rsp_zero),
    .busy(busy)
`ifdef ALU_SELFCHECK_EN
    , .chk_err(chk_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ALU model: outputs are wrong until inputs have been stable across S falling edges.
  logic [2*WIDTH+1:0] alu_prev = 'x;
  int alu_stable = 0;
  always @(negedge clk) begin : alu_model
    int sa, sb, d;
    logic [WIDTH-1:0] r;
    if ({alu_a, alu_b, alu_op} !== alu_prev) begin
      alu_prev   = {alu_a, alu_b, alu_op};
      alu_stable = 1;
    end else if (alu_stable < 1000) begin
      alu_stable++;
    end
    sa = $signed(alu_a);
    sb = $signed(alu_b);
    d  = alu_op[0] ? (sa - sb) : (sa + sb + (corrupt_add ? 1 : 0));
    r  = d[WIDTH-1:0];
    if (alu_stable >= S) begin
      alu_result   = r;
      alu_overflow = (d > MAXS) || (d < MINS);
      alu_zero     = (r == 0);
    end else begin
      alu_result   = ~r;
      alu_overflow = !((d > MAXS) || (d < MINS));
      alu_zero     = (r != 0);
    end
  end

  function automatic void predict(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic [1:0] op, input bit corrupt,
                                  output logic [WIDTH-1:0] res, output logic ov, output logic z,
                                  output int lat, output logic [WIDTH-1:0] p1, output bit second);
    int sa, sb, d1, d2;
    logic [WIDTH-1:0] r1, r2;
    logic ov1;
    sa  = $signed(a);
    sb  = $signed(b);
    d1  = (op == 2'b01 || op == 2'b10) ? (sa - sb) : (sa + sb + (corrupt ? 1 : 0));
    r1  = d1[WIDTH-1:0];
    ov1 = (d1 > MAXS) || (d1 < MINS);
    p1  = r1;
    if (op != 2'b10 || !r1[WIDTH-1]) begin
      res = r1; ov = ov1; z = (r1 == 0); lat = S; second = 0;
    end else begin
      d2  = 0 - $signed(r1);
      r2  = d2[WIDTH-1:0];
      res = r2; ov = ov1 | (d2 > MAXS); z = (r2 == 0); lat = 2 * S; second = 1;
    end
  endfunction

  // Transaction-level reference: 0 idle, 1 computing, 2 response pending.
  int m_phase = 0;
  int m_elapsed = 0;
  int m_lat = 0;
  bit m_second = 0;
  logic [WIDTH-1:0] m_res = '0, m_p1 = '0, e_a = '0, e_b = '0;
  logic m_ov = 0, m_z = 0;
  logic [1:0] e_op = '0;

  always @(posedge clk) begin : monitor
    logic r, cv, rr;
    logic [WIDTH-1:0] ca, cb;
    logic [1:0] co;
    r = rst_n; cv = cmd_valid; rr = rsp_ready; ca = cmd_a; cb = cmd_b; co = cmd_op;
    #1;
    if (!r) begin
      m_phase = 0; e_a = '0; e_b = '0; e_op = '0; m_res = '0; m_ov = 0; m_z = 0;
    end else begin
      case (m_phase)
        0: if (cv) begin
          predict(ca, cb, co, corrupt_add, m_res, m_ov, m_z, m_lat, m_p1, m_second);
          e_a = ca; e_b = cb; e_op = (co == 2'b01 || co == 2'b10) ? 2'b01 : 2'b00;
          m_elapsed = 0; m_phase = 1;
        end
        1: begin
          m_elapsed++;
          if (m_second && m_elapsed == S) begin
            e_a = '0; e_b = m_p1; e_op = 2'b01;
          end
          if (m_elapsed == m_lat) m_phase = 2;
        end
        default: if (rr) m_phase = 0;
      endcase
    end
    chk("mon_cmd_ready", cmd_ready, m_phase == 0);
    chk("mon_busy", busy, m_phase != 0);
    chk("mon_rsp_valid", rsp_valid, m_phase == 2);
    chk("mon_alu_a", alu_a, e_a);
    chk("mon_alu_b", alu_b, e_b);
    chk("mon_alu_op", alu_op, e_op);
    if (m_phase != 1) begin
      chk("mon_rsp_result", rsp_result, m_res);
      chk("mon_rsp_overflow", rsp_overflow, m_ov);
      chk("mon_rsp_zero", rsp_zero, m_z);
    end
  end

  // Issues one command from a falling edge; returns just after the response handshake edge.
  task automatic run(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [1:0] op,
                     input int hold, output logic [WIDTH-1:0] res, output logic ov,
                     output logic z, output int lat);
    int k;
    k = 0;
    while (!cmd_ready && k < 50) begin @(negedge clk); k++; end
    chk("ready_wait", cmd_ready, 1);
    cmd_valid = 1; cmd_a = a; cmd_b = b; cmd_op = op;
    rsp_ready = (hold == 0);
    @(posedge clk);
    lat = 0;
    while (lat < 64) begin
      @(negedge clk);
      if (rsp_valid) break;
      lat++;
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_a = 4'($urandom); cmd_b = 4'($urandom); cmd_op = 2'($urandom);
    end
    chk("rsp_valid_wait", rsp_valid, 1);
    res = rsp_result; ov = rsp_overflow; z = rsp_zero;
    repeat (hold) begin
      cmd_valid = 1; cmd_a = 4'($urandom); cmd_b = 4'($urandom); cmd_op = 2'($urandom);
      @(negedge clk);
    end
    cmd_valid = 0;
    rsp_ready = 1;
    @(posedge clk);
  endtask

  task automatic expect_rsp(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic [1:0] op, input int hold, input logic [WIDTH-1:0] x_res,
                            input logic x_ov, input logic x_z, input int x_lat);
    logic [WIDTH-1:0] res;
    logic ov, z;
    int lat;
    run(a, b, op, hold, res, ov, z, lat);
    chk({name, "_result"}, res, x_res);
    chk({name, "_overflow"}, ov, x_ov);
    chk({name, "_zero"}, z, x_z);
    chk({name, "_latency"}, lat, x_lat);
    #1 chk({name, "_ready_after"}, cmd_ready, 1);
    @(negedge clk);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int seen;
    logic [WIDTH-1:0] res;
    logic ov, z;
    int lat;
    rst_n = 0; cmd_valid = 0; cmd_a = '0; cmd_b = '0; cmd_op = '0; rsp_ready = 0;
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_rsp_result", rsp_result, 0);
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    expect_rsp("add_3_4", 4'd3, 4'd4, 2'b00, 0, 4'b0111, 0, 0, S);
    expect_rsp("sub_5_5", 4'd5, 4'd5, 2'b01, 0, 4'b0000, 0, 1, S);
    expect_rsp("add_7_1", 4'd7, 4'd1, 2'b00, 0, 4'b1000, 1, 0, S);
    expect_rsp("abs_2_6", 4'd2, 4'd6, 2'b10, 0, 4'b0100, 0, 0, 2 * S);
    expect_rsp("abs_m8_0", 4'b1000, 4'd0, 2'b10, 0, 4'b1000, 1, 0, 2 * S);
    expect_rsp("abs_6_2", 4'd6, 4'd2, 2'b10, 0, 4'b0100, 0, 0, S);
    expect_rsp("hold_3_2", 4'd3, 4'd2, 2'b00, 5, 4'b0101, 0, 0, S);
    expect_rsp("op11_6_1", 4'd6, 4'd1, 2'b11, 0, 4'b0111, 0, 0, S);

    // Reset during the negate pass of ABS_DIFF 2,6.
    cmd_valid = 1; cmd_a = 4'd2; cmd_b = 4'd6; cmd_op = 2'b10; rsp_ready = 1;
    @(posedge clk);
    @(negedge clk) cmd_valid = 0;
    repeat (S - 1) @(posedge clk);
    @(posedge clk);
    #2;
    chk("w2_alu_a", alu_a, 0);
    chk("w2_alu_b", alu_b, 4'b1100);
    chk("w2_alu_op", alu_op, 2'b01);
    #1 rst_n = 0;
    #1;
    chk("arst_cmd_ready", cmd_ready, 1);
    chk("arst_busy", busy, 0);
    chk("arst_alu_b", alu_b, 0);
    chk("arst_alu_op", alu_op, 0);
    chk("arst_rsp_result", rsp_result, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    seen = 0;
    repeat (2 * S + 3) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("no_rsp_after_reset", seen, 0);
    expect_rsp("sub_4_5", 4'd4, 4'd5, 2'b01, 0, 4'b1111, 0, 0, S);

    repeat (200) begin
      run(4'($urandom), 4'($urandom), 2'($urandom), $urandom_range(0, 3), res, ov, z, lat);
      @(negedge clk);
      rsp_ready = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

`ifdef ALU_SELFCHECK_EN
    chk("chk_err_clean", chk_err, 0);
    corrupt_add = 1;
    expect_rsp("corrupt_add", 4'd3, 4'd4, 2'b00, 0, 4'b1000, 1, 0, S);
    corrupt_add = 0;
    chk("chk_err_set", chk_err, 1);
    expect_rsp("after_corrupt", 4'd1, 4'd1, 2'b00, 0, 4'b0010, 0, 0, S);
    chk("chk_err_sticky", chk_err, 1);
    rst_n = 0;
    #1 chk("chk_err_reset", chk_err, 0);
    @(negedge clk) rst_n = 1;
    @(negedge clk);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
